// File: rtl/wavlet_coef_pack.sv
// Wavelet coefficient packer: soft-thresholds hd, rounds/scales/saturates both
// coefficients, buffers pairs in a FIFO and emits them as ld/hd beats.
module wavlet_coef_pack #(
   parameter int DEPTH = 8,
   parameter int SHIFT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic signed [20:0] in_hd,
   input  logic signed [20:0] in_ld,
   input  logic        [19:0] thr,
   output logic               in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [15:0] out_data,
   output logic               out_is_hd,
   output logic        [15:0] drop_cnt,
   output logic               sat_flag
);

   // state | meaning
   // S_LD  | presenting ld of the FIFO head
   // S_HD  | presenting hd of the FIFO head; handshake here pops the pair
   typedef enum logic {S_LD = 1'b0, S_HD = 1'b1} state_t;

   localparam int AW = $clog2(DEPTH);
   localparam logic signed [21:0] RND = 22'sd1 <<< (SHIFT - 1);

   function automatic logic [16:0] f_scale(input logic signed [21:0] x);
      logic signed [21:0] r;
      logic        [16:0] res;
      r = (x + RND) >>> SHIFT;
      if (r > 22'sd32767)
         res = {1'b1, 16'h7FFF};
      else if (r < -22'sd32768)
         res = {1'b1, 16'h8000};
      else
         res = {1'b0, r[15:0]};
      return res;
   endfunction

   state_t              r_state;
   logic [31:0]         r_mem [DEPTH];
   logic [AW-1:0]       r_wr;
   logic [AW-1:0]       r_rd;
   logic [AW:0]         r_count;
   logic                r_p_valid;
   logic [15:0]         r_p_ld;
   logic [15:0]         r_p_hd;
   logic [15:0]         r_drop;
   logic                r_sat;

   logic signed [21:0]  w_hd_x;
   logic signed [21:0]  w_ld_x;
   logic signed [21:0]  w_thr_x;
   logic signed [21:0]  w_abs;
   logic signed [21:0]  w_hd_t;
   logic [16:0]         w_hd_r;
   logic [16:0]         w_ld_r;
   logic [AW+1:0]       w_occ;
   logic                w_accept;
   logic                w_drop;
   logic                w_out_valid;
   logic                w_pop;
   logic [31:0]         w_head;

   always_comb begin
      w_hd_x  = {in_hd[20], in_hd};
      w_ld_x  = {in_ld[20], in_ld};
      w_thr_x = $signed({2'b00, thr});
      w_abs   = in_hd[20] ? -w_hd_x : w_hd_x;
      w_hd_t  = 22'sd0;
      if (w_abs > w_thr_x)
         w_hd_t = in_hd[20] ? (w_hd_x + w_thr_x) : (w_hd_x - w_thr_x);
      w_hd_r  = f_scale(w_hd_t);
      w_ld_r  = f_scale(w_ld_x);
   end

   // P counts toward occupancy so the FIFO always has room for it next edge
   assign w_occ       = (AW+2)'(r_count) + (AW+2)'(r_p_valid);
   assign in_ready    = !rst && (w_occ < (AW+2)'(DEPTH));
   assign w_accept    = in_valid && in_ready;
   assign w_drop      = in_valid && !in_ready;
   assign w_out_valid = !rst && (r_count != '0);
   assign w_pop       = w_out_valid && out_ready && (r_state == S_HD);
   assign w_head      = r_mem[r_rd];

   assign out_valid = w_out_valid;
   assign out_is_hd = !rst && (r_state == S_HD);
   assign out_data  = !w_out_valid ? 16'sd0 :
                      (r_state == S_HD) ? w_head[15:0] : w_head[31:16];
   assign drop_cnt  = rst ? 16'd0 : r_drop;
   assign sat_flag  = !rst && r_sat;

   always_ff @(posedge clk) begin
      if (!rst && r_p_valid)
         r_mem[r_wr] <= {r_p_ld, r_p_hd};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_LD;
         r_wr      <= '0;
         r_rd      <= '0;
         r_count   <= '0;
         r_p_valid <= 1'b0;
         r_p_ld    <= '0;
         r_p_hd    <= '0;
         r_drop    <= '0;
         r_sat     <= 1'b0;
      end else begin
         r_p_valid <= w_accept;
         if (w_accept) begin
            r_p_ld <= w_ld_r[15:0];
            r_p_hd <= w_hd_r[15:0];
            if (w_ld_r[16] || w_hd_r[16])
               r_sat <= 1'b1;
         end
         if (w_drop && (r_drop != 16'hFFFF))
            r_drop <= r_drop + 16'd1;
         if (r_p_valid)
            r_wr <= r_wr + 1'b1;
         if (w_pop)
            r_rd <= r_rd + 1'b1;
         case ({r_p_valid, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_out_valid && out_ready) begin
            case (r_state)
               S_LD:    r_state <= S_HD;
               S_HD:    r_state <= S_LD;
               default: r_state <= S_LD;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wavlet_coef_pack.sv
// Scoreboard bench for wavlet_coef_pack (DEPTH=8, SHIFT=4) with directed vectors.
module tb_wavlet_coef_pack;

   typedef struct {
      logic signed [15:0] d;
      logic               h;
   } beat_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic signed [20:0] in_hd = '0;
   logic signed [20:0] in_ld = '0;
   logic        [19:0] thr = '0;
   logic               in_ready;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic signed [15:0] out_data;
   logic               out_is_hd;
   logic        [15:0] drop_cnt;
   logic               sat_flag;

   beat_t q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   wavlet_coef_pack #(.DEPTH(8), .SHIFT(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_hd(in_hd), .in_ld(in_ld),
      .thr(thr), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_is_hd(out_is_hd), .drop_cnt(drop_cnt),
      .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // monitor: every handshake beat is compared against the queue head
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_beat", int'(out_data), 99999);
            end else begin
               e = q.pop_front();
               chk("beat_data", int'(out_data), int'(e.d));
               chk("beat_is_hd", int'(out_is_hd), int'(e.h));
            end
         end
      end
   end

   // called at posedge+1; drives one cycle of in_valid
   task automatic send(input int hd, input int ld, input int t,
                       input int e_ld, input int e_hd, input bit acc);
      in_valid = 1'b1;
      in_hd = 21'(hd);
      in_ld = 21'(ld);
      thr   = 20'(t);
      @(negedge clk);
      chk("in_ready_at_send", int'(in_ready), int'(acc));
      if (acc) begin
         q.push_back('{d: 16'(e_ld), h: 1'b0});
         q.push_back('{d: 16'(e_hd), h: 1'b1});
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int max_cyc);
      int n = 0;
      while (q.size() != 0 && n < max_cyc) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_timeout_left", q.size(), 0);
   endtask

   initial begin
      logic [3:0]         pat;
      logic signed [15:0] s_d;
      logic               s_h;
      bit                 have_prev;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_is_hd", int'(out_is_hd), 0);
      chk("rst_drop", int'(drop_cnt), 0);
      chk("rst_sat", int'(sat_flag), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;

      // basic with latency: accepted in t, ld at t+2, hd at t+3
      out_ready = 1'b1;
      send(1000, 1600, 100, 100, 56, 1'b1);
      @(negedge clk);
      chk("lat_t1_valid", int'(out_valid), 0);
      @(negedge clk);
      chk("lat_t2_valid", int'(out_valid), 1);
      chk("lat_t2_is_hd", int'(out_is_hd), 0);
      @(negedge clk);
      chk("lat_t3_is_hd", int'(out_is_hd), 1);
      @(posedge clk); #1;
      wait_drain(20);

      // threshold and rounding
      send(-80, 0, 100, 0, 0, 1'b1);
      send(-356, 0, 100, 0, -16, 1'b1);
      send(500, -40, 20, -2, 30, 1'b1);
      wait_drain(20);
      chk("thr_sat_flag", int'(sat_flag), 0);

      // saturation
      send(0, 1048575, 0, 32767, 0, 1'b1);
      @(negedge clk);
      chk("sat_flag_set", int'(sat_flag), 1);
      @(posedge clk); #1;
      send(0, -1048576, 0, -32768, 0, 1'b1);
      send(1048575, 0, 0, 0, 32767, 1'b1);
      wait_drain(20);
      chk("sat_flag_sticky", int'(sat_flag), 1);

      // overflow: 12 offers with sink stalled, first 8 accepted
      out_ready = 1'b0;
      for (int i = 0; i < 12; i++)
         send(-32*i - 16, 32*i, 0, 2*i, -2*i - 1, i < 8);
      @(negedge clk);
      chk("ovf_drop", int'(drop_cnt), 4);
      chk("ovf_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_drain(40);

      // stall stability with out_ready 1,0,0,1
      out_ready = 1'b0;
      send(-200, 333, 20, 21, -11, 1'b1);
      send(700, -700, 50, -44, 41, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      pat = 4'b1001;
      have_prev = 1'b0;
      for (int k = 0; k < 40 && q.size() != 0; k++) begin
         out_ready = pat[k % 4];
         @(negedge clk);
         if (have_prev) begin
            chk("stall_data_hold", int'(out_data), int'(s_d));
            chk("stall_is_hd_hold", int'(out_is_hd), int'(s_h));
         end
         have_prev = out_valid && !out_ready;
         s_d = out_data;
         s_h = out_is_hd;
         @(posedge clk); #1;
      end
      chk("stall_left", q.size(), 0);

      // reset mid-stream: 3 pairs buffered, in S_HD, drop_cnt=2
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++)
         send(-32*i - 16, 32*i, 0, 2*i, -2*i - 1, i < 8);
      out_ready = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("mid_drop", int'(drop_cnt), 2);
      chk("mid_in_hd_state", int'(out_is_hd), 1);
      chk("mid_valid", int'(out_valid), 1);
      @(posedge clk); #1;
      rst = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_valid_during", int'(out_valid), 0);
      chk("midrst_ready_during", int'(in_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      @(negedge clk);
      chk("midrst_valid", int'(out_valid), 0);
      chk("midrst_drop", int'(drop_cnt), 0);
      chk("midrst_sat", int'(sat_flag), 0);
      chk("midrst_in_ready", int'(in_ready), 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("midrst_no_stale", int'(out_valid), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/wavlet_coef_pack.md
WAVLET_COEF_PACK -- requirements
Module: wavlet_coef_pack

Interface
REQ-001 Parameter DEPTH, default 8: FIFO capacity in coefficient pairs, power of two, at least 4.
REQ-002 Parameter SHIFT, default 4: right-shift applied to every coefficient before 16-bit saturation, range 1..8.
REQ-003 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-004 Port clk, in, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, in, 1: synchronous active-high reset.
REQ-006 Port in_valid, in, 1: an hd/ld pair from the wavelet decomposition stage is present.
REQ-007 Port in_hd, in, 21 signed: high-band (detail) coefficient.
REQ-008 Port in_ld, in, 21 signed: low-band (approximation) coefficient.
REQ-009 Port thr, in, 20 unsigned: soft-threshold magnitude for hd, sampled at pair acceptance.
REQ-010 Port in_ready, out, 1: the block can accept a pair this cycle.
REQ-011 Port out_valid, out, 1: out_data holds a valid beat.
REQ-012 Port out_ready, in, 1: the sink accepts the beat.
REQ-013 Port out_data, out, 16 signed: output coefficient beat.
REQ-014 Port out_is_hd, out, 1: 0 = ld beat, 1 = hd beat.
REQ-015 Port drop_cnt, out, 16 unsigned: count of pairs dropped because the FIFO was full.
REQ-016 Port sat_flag, out, 1: sticky flag, set when any coefficient saturated.

Function
REQ-017 A pair SHALL be accepted in a cycle where in_valid=1 and in_ready=1.
REQ-018 Definition: occupancy = FIFO entries + pipeline register P valid.
REQ-019 in_ready SHALL equal (occupancy < DEPTH) and SHALL be decoded from registers only.
REQ-020 If in_valid=1 and in_ready=0, the pair SHALL be discarded and drop_cnt SHALL increment, saturating at 65535.
REQ-021 Threshold on hd: if |hd| <= thr, the result SHALL be 0; otherwise hd - sign(hd)*thr. ld SHALL pass unmodified.
REQ-022 Threshold arithmetic SHALL be carried out in at least 22 bits signed.
REQ-023 Scaling for each coefficient x: y = (x + 2^(SHIFT-1)) >>> SHIFT, an arithmetic shift (round half up), computed in 22 bits.
REQ-024 Saturation: y SHALL be clamped to [-32768, 32767].
REQ-025 Any clamp event SHALL set sat_flag, which stays set until reset.
REQ-026 Pipeline: threshold, scaling and saturation results SHALL be registered in P at the acceptance edge.
REQ-027 P SHALL move into the FIFO at the next edge.
REQ-028 Latency: with the FIFO empty, a pair accepted in cycle t SHALL produce out_valid=1 in cycle t+2.
REQ-029 The output FSM SHALL have two states: S_LD (out_is_hd=0, emits the ld of the FIFO head) and S_HD (out_is_hd=1, emits the hd of the FIFO head).
REQ-030 Transitions: S_LD to S_HD on out_valid and out_ready; S_HD to S_LD on out_valid and out_ready, which also pops the FIFO head.
REQ-031 out_valid SHALL be 1 exactly when the FIFO is non-empty.
REQ-032 While out_valid=1 and out_ready=0, out_data and out_is_hd SHALL hold stable.
REQ-033 A simultaneous push and pop SHALL leave the FIFO count unchanged.
REQ-034 The FIFO SHALL never be overwritten when full, guaranteed by REQ-019.
REQ-035 Read and write pointers SHALL wrap modulo DEPTH.
REQ-036 Pair order and beat order (ld then hd) SHALL be preserved for all backpressure patterns.

Reset
REQ-037 While rst=1 at a clock edge, the block SHALL clear the FIFO, clear P, and set the FSM to S_LD.
REQ-038 While rst=1, the block SHALL zero drop_cnt and sat_flag.
REQ-039 While rst=1, out_valid, out_data and out_is_hd SHALL be 0.
REQ-040 While rst=1, in_ready SHALL be 0.
REQ-041 In the first cycle after rst deasserts, in_ready SHALL be 1.
REQ-042 Reset mid-operation SHALL discard all buffered pairs and any partially emitted pair, with no beat emitted afterward from pre-reset data.

Verification (SHIFT=4, DEPTH=8)
REQ-043 Basic: hd=1000, ld=1600, thr=100, out_ready=1 -> beats 100 (is_hd=0) in cycle t+2, then 56 (is_hd=1) in cycle t+3.
REQ-044 Threshold and rounding: hd=-80, thr=100 -> hd beat 0; hd=-356, thr=100 -> hd beat -16; sat_flag stays 0.
REQ-045 Saturation: ld=1048575 -> 32767 and ld=-1048576 -> -32768; sat_flag=1 from the cycle after the first clamp.
REQ-046 Overflow: out_ready=0, in_valid=1 for 12 cycles -> 8 pairs accepted, in_ready=0 thereafter, drop_cnt=4; then out_ready=1 -> 16 beats alternating ld/hd in input order.
REQ-047 Stall stability: out_ready pattern 1,0,0,1 -> out_data/out_is_hd constant during the 0 cycles, no beat lost or duplicated.
REQ-048 Reset mid-stream: 3 pairs buffered, in S_HD, drop_cnt=2, rst=1 for one cycle -> next cycle out_valid=0, drop_cnt=0, sat_flag=0, in_ready=1.
